// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
// Shares the single-port command RAM between the SPI slave front end and a
// local host port. An address command (00/10) locks the RAM to its source until
// that source sends the matching data command (01/11) or the lock times out.
// Read data (opcode 11) is routed back to whichever source owns the read.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   s_rx_data/s_rx_valid     SPI command words (1-entry skid buffer, no backpressure)
//   s_tx_data/s_tx_valid     read data returned to SPI (1-cycle strobe)
//   h_cmd/h_valid/h_ready    host command handshake (h_ready is combinational)
//   h_rdata/h_rvalid         read data returned to host (1-cycle strobe)
//   ram_din/ram_rx_valid     registered command stream to the RAM
//   ram_dout/ram_tx_valid    RAM read data
//   owner                    current/last grant (0 = SPI, 1 = host)
//   busy                     state is not IDLE
//   ovf                      sticky: an SPI word was dropped
//   to_err                   1-cycle pulse on lock or read timeout
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int LOCK_TIMEOUT = 64,
    parameter int RD_TIMEOUT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] s_rx_data,
    input  logic       s_rx_valid,
    output logic [7:0] s_tx_data,
    output logic       s_tx_valid,
    input  logic [9:0] h_cmd,
    input  logic       h_valid,
    output logic       h_ready,
    output logic [7:0] h_rdata,
    output logic       h_rvalid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       owner,
    output logic       busy,
    output logic       ovf,
    output logic       to_err
);

    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(RD_TIMEOUT + 1);

    localparam logic SRC_SPI  = 1'b0;
    localparam logic SRC_HOST = 1'b1;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOCK    = 2'b01,
        ST_RD_WAIT = 2'b10
    } state_t;

    // Where an accepted command takes the arbiter, decided by its opcode alone.
    function automatic state_t route_state(input logic [1:0] op);
        state_t st;
        case (op)
            OP_WR_ADDR, OP_RD_ADDR: st = ST_LOCK;
            OP_WR_DATA:             st = ST_IDLE;
            OP_RD_DATA:             st = ST_RD_WAIT;
            default:                st = ST_IDLE;
        endcase
        return st;
    endfunction

    state_t          state_r, state_nxt_s;
    logic            buf_valid_r;
    logic [9:0]      buf_data_r;
    logic            last_r;
    logic            owner_r;
    logic [LW-1:0]   lock_cnt_r, lock_cnt_nxt_s;
    logic [RW-1:0]   rd_cnt_r, rd_cnt_nxt_s;
    logic            accept_s;
    logic            grant_s;
    logic [9:0]      cmd_s;
    logic            pop_s;
    logic            lock_to_s;
    logic            rd_to_s;
    logic            rd_done_s;
    logic [9:0]      ram_din_r;
    logic            ram_rx_valid_r;
    logic [7:0]      s_tx_data_r;
    logic            s_tx_valid_r;
    logic [7:0]      h_rdata_r;
    logic            h_rvalid_r;
    logic            ovf_r;
    logic            to_err_r;

    // Grant selection: round-robin in IDLE, owner-only in LOCK, nothing in RD_WAIT.
    always_comb begin
        accept_s = 1'b0;
        grant_s  = SRC_SPI;
        case (state_r)
            ST_IDLE: begin
                if (buf_valid_r && h_valid) begin
                    // Tie: the source that was not granted last wins.
                    accept_s = 1'b1;
                    grant_s  = ~last_r;
                end else if (buf_valid_r) begin
                    accept_s = 1'b1;
                    grant_s  = SRC_SPI;
                end else if (h_valid) begin
                    accept_s = 1'b1;
                    grant_s  = SRC_HOST;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_LOCK: begin
                if ((owner_r == SRC_SPI) && buf_valid_r) begin
                    accept_s = 1'b1;
                    grant_s  = SRC_SPI;
                end else if ((owner_r == SRC_HOST) && h_valid) begin
                    accept_s = 1'b1;
                    grant_s  = SRC_HOST;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_RD_WAIT: accept_s = 1'b0;
            default:    accept_s = 1'b0;
        endcase
    end

    // Mux the granted command and derive the buffer pop.
    always_comb begin
        if (grant_s == SRC_HOST) begin
            cmd_s = h_cmd;
        end else begin
            cmd_s = buf_data_r;
        end
        pop_s = accept_s && (grant_s == SRC_SPI);
    end

    // Next-state logic with lock-idle and read-wait timeouts.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        rd_cnt_nxt_s   = rd_cnt_r;
        lock_to_s      = 1'b0;
        rd_to_s        = 1'b0;
        rd_done_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOCK: begin
                if (accept_s) begin
                    state_nxt_s    = route_state(cmd_s[9:8]);
                    lock_cnt_nxt_s = {LW{1'b0}};
                    rd_cnt_nxt_s   = {RW{1'b0}};
                end else if (state_r == ST_LOCK) begin
                    // This idle cycle is the LOCK_TIMEOUT-th in a row.
                    if (lock_cnt_r == LW'(LOCK_TIMEOUT - 1)) begin
                        lock_to_s      = 1'b1;
                        state_nxt_s    = ST_IDLE;
                        lock_cnt_nxt_s = {LW{1'b0}};
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r + LW'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // The first RD_WAIT cycle is the RAM strobe cycle itself, so
                // the counter reaching RD_TIMEOUT means RD_TIMEOUT cycles after it.
                if (ram_tx_valid) begin
                    rd_done_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    rd_cnt_nxt_s = {RW{1'b0}};
                end else if (rd_cnt_r == RW'(RD_TIMEOUT)) begin
                    rd_to_s      = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    rd_cnt_nxt_s = {RW{1'b0}};
                end else begin
                    rd_cnt_nxt_s = rd_cnt_r + RW'(1);
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, counters, grant pointer and owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= {LW{1'b0}};
            rd_cnt_r   <= {RW{1'b0}};
            last_r     <= SRC_HOST;
            owner_r    <= SRC_SPI;
            to_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            rd_cnt_r   <= rd_cnt_nxt_s;
            to_err_r   <= lock_to_s | rd_to_s;
            if (accept_s) begin
                last_r  <= grant_s;
                owner_r <= grant_s;
            end
        end
    end

    // Registered command stream to the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_din_r      <= 10'd0;
            ram_rx_valid_r <= 1'b0;
        end else begin
            ram_rx_valid_r <= accept_s;
            if (accept_s) begin
                ram_din_r <= cmd_s;
            end
        end
    end

    // Read data return, routed to the owner of the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_tx_data_r  <= 8'd0;
            s_tx_valid_r <= 1'b0;
            h_rdata_r    <= 8'd0;
            h_rvalid_r   <= 1'b0;
        end else begin
            s_tx_valid_r <= rd_done_s && (owner_r == SRC_SPI);
            h_rvalid_r   <= rd_done_s && (owner_r == SRC_HOST);
            if (rd_done_s && (owner_r == SRC_SPI)) begin
                s_tx_data_r <= ram_dout;
            end
            if (rd_done_s && (owner_r == SRC_HOST)) begin
                h_rdata_r <= ram_dout;
            end
        end
    end

    // SPI skid buffer: a push during a pop replaces the word; a push into a
    // full, unpopped buffer is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 10'd0;
            ovf_r       <= 1'b0;
        end else if (s_rx_valid) begin
            if (pop_s || !buf_valid_r) begin
                buf_valid_r <= 1'b1;
                buf_data_r  <= s_rx_data;
            end else begin
                ovf_r <= 1'b1;
            end
        end else if (pop_s) begin
            buf_valid_r <= 1'b0;
        end
    end

    assign h_ready      = accept_s && (grant_s == SRC_HOST) && !rst;
    assign ram_din      = ram_din_r;
    assign ram_rx_valid = ram_rx_valid_r;
    assign s_tx_data    = s_tx_data_r;
    assign s_tx_valid   = s_tx_valid_r;
    assign h_rdata      = h_rdata_r;
    assign h_rvalid     = h_rvalid_r;
    assign owner        = owner_r;
    assign busy         = (state_r != ST_IDLE);
    assign ovf          = ovf_r;
    assign to_err       = to_err_r;

endmodule
